quad_collector: RTL and testbench
=================================

QUAD_COLLECTOR -- requirements
Module: quad_collector

Interface
REQ-001 Parameter: WIDTH, 8, bit width of one sample word.
REQ-002 Parameter: DEPTH, 4, quad FIFO entries; power of two, 2..16.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  WIDTH  sample word from the upstream 4-point transform stage.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle; no backpressure toward upstream.
REQ-007 Port: in_sof  input  1  qualifies in_data as word 0 of a 4-word group; meaningful only when in_valid=1.
REQ-008 Port: out_quad  output  4*WIDTH  FIFO head, packed {w3,w2,w1,w0}, w0 in the LSBs.
REQ-009 Port: out_valid  output  1  FIFO non-empty.
REQ-010 Port: out_ready  input  1  consumer accepts out_quad this cycle.
REQ-011 Port: frame_err  output  1  one-cycle pulse on a framing error.
REQ-012 Port: overflow  output  1  one-cycle pulse when a completed quad is dropped.
REQ-013 Port: drop_cnt  output  8  count of dropped quads, saturating at 255.
REQ-014 Port: level  output  clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-015 Collector FSM states: IDLE, GOT1, GOT2, GOT3; a word is accepted only on a clk edge with in_valid=1.
REQ-016 IDLE, word with in_sof=1: store as w0, go to GOT1.
REQ-017 IDLE, word with in_sof=0: discard, pulse frame_err, stay in IDLE.
REQ-018 GOT1/GOT2, word with in_sof=0: store as w1/w2, advance to GOT2/GOT3.
REQ-019 GOT3, word with in_sof=0: store as w3, push {w3,w2,w1,w0} in the same edge, go to IDLE.
REQ-020 GOT1/GOT2/GOT3, word with in_sof=1: discard the partial group, pulse frame_err, store the word as the new w0, go to GOT1.
REQ-021 in_valid=0 in any state: hold state and stored words; no pulse.
REQ-022 Latency: out_valid=1 and out_quad show the pushed group on the cycle after the edge accepting w3, when the FIFO was empty.
REQ-023 Pop occurs when out_valid=1 and out_ready=1 on a clk edge; out_quad is held stable while out_valid=1 and out_ready=0.
REQ-024 Push to a full FIFO with no pop in the same edge: drop the quad, pulse overflow, increment drop_cnt (saturating at 255), leave FIFO contents unchanged.
REQ-025 Push and pop in the same edge when full: both are performed, no overflow, level stays DEPTH.
REQ-026 Push and pop in the same edge when non-full: level is unchanged.
REQ-027 FIFO read and write pointers wrap modulo DEPTH; order is strictly first-in first-out.
REQ-028 level is updated on the same edge as each push or pop; out_valid = (level != 0).
REQ-029 frame_err and overflow are registered and asserted for exactly the cycle following the causing edge.
REQ-030 A frame_err and an overflow from the same edge are both reported.

Reset
REQ-031 reset=0 asynchronously forces: FSM to IDLE; partial words discarded; FIFO empty; level=0; out_valid=0; frame_err=0; overflow=0; drop_cnt=0; out_quad=0.
REQ-032 Reset asserted mid-group or with a non-empty FIFO loses all data; no pulses on release.
REQ-033 The first edge after reset release processes inputs normally.

Verification
REQ-034 Input words 0x10(sof),0x20,0x30,0x40, out_ready=1 -> one cycle after the 4th word: out_valid=1, out_quad=0x40302010; popped next edge, level returns to 0.
REQ-035 Words 0x01(sof),0x02,0x03(sof),0x04,0x05,0x06 -> frame_err pulses once; single quad 0x06050403 output.
REQ-036 out_ready=0, five complete groups (DEPTH=4) -> level=4, 5th group dropped, overflow pulses, drop_cnt=1; draining returns groups 1..4 in order.
REQ-037 FIFO full, out_ready=1 on the edge completing another group -> no overflow, level stays 4, new group is the last entry.
REQ-038 Words 0xAA(sof),0xBB, reset pulsed low, then 0xCC,0xDD without sof -> no quad output, two frame_err pulses, level=0.
REQ-039 Group with in_valid gaps between words (e.g. 3 idle cycles after w1) -> same quad as the gap-free case; no frame_err.

Source files
------------

// File: rtl/quad_collector.sv
// Collects four sample words framed by a start-of-group marker into one packed
// quad and queues completed quads in a small FIFO; counts quads lost to overflow.
module quad_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_sof,
  output logic [4*WIDTH-1:0]         out_quad,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, GOT1, GOT2, GOT3} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   w0, w1, w2;
  logic               store_w0, store_w1, store_w2;
  logic               push_req, frame_err_next;

  logic [4*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level_next;
  logic               full, pop, push_ok, overflow_next;

  // Collector FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Collector FSM: next state. A word with in_sof always restarts a group.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      if (in_sof) begin
        state_next = GOT1;
      end else begin
        unique case (state)
          IDLE: state_next = IDLE;
          GOT1: state_next = GOT2;
          GOT2: state_next = GOT3;
          GOT3: state_next = IDLE;
        endcase
      end
    end
  end

  // Collector FSM: decoded actions for the current word
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    store_w0       = 1'b0;
    store_w1       = 1'b0;
    store_w2       = 1'b0;
    push_req       = 1'b0;
    frame_err_next = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        store_w0       = 1'b1;
        frame_err_next = (state != IDLE);
      end else begin
        store_w1       = (state == GOT1);
        store_w2       = (state == GOT2);
        push_req       = (state == GOT3);
        frame_err_next = (state == IDLE);
      end
    end
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else begin
      if (store_w0) w0 <= in_data;
      if (store_w1) w1 <= in_data;
      if (store_w2) w2 <= in_data;
    end
  end

  // w3 is never stored: the final word goes straight into the FIFO with w0..w2.
  assign full          = (level == LW'(DEPTH));
  assign pop           = out_valid && out_ready;
  assign push_ok       = push_req && (!full || pop);
  assign overflow_next = push_req && full && !pop;

  always_comb begin
    level_next = level;
    unique case ({push_ok, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by level, and
  // out_quad is forced to zero while empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {in_data, w2, w1, w0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level     <= level_next;
      frame_err <= frame_err_next;
      overflow  <= overflow_next;
      if (overflow_next && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign out_valid = (level != '0);
  assign out_quad  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_quad_collector.sv
// Self-checking bench for quad_collector: framing vectors from a table, hand-written
// FIFO fill/overflow/reset sequences, and a queue scoreboard checking every pop.
module tb_quad_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic              in_sof;
  logic [4*WIDTH-1:0] out_quad;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        sof;
    logic        ferr;
    logic        push;
    logic [31:0] quad;
  } vec_t;

  vec_t vecs[$];

  quad_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_quad  (out_quad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a pop happens on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", out_quad, 32'h0);
        check("unexpected_pop_flag", 32'd1, 32'd0);
      end else begin
        check("pop_quad", out_quad, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic r);
    in_data   = d;
    in_valid  = v;
    in_sof    = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] quad_of(input logic [7:0] base);
    logic [7:0] b1, b2, b3, b4;
    b1 = base + 8'd1;
    b2 = base + 8'd2;
    b3 = base + 8'd3;
    b4 = base + 8'd4;
    return {b4, b3, b2, b1};
  endfunction

  task automatic send_group(input logic [7:0] base, input logic r, input logic last_r);
    drive(base + 8'd1, 1'b1, 1'b1, r);
    drive(base + 8'd2, 1'b1, 1'b0, r);
    drive(base + 8'd3, 1'b1, 1'b0, r);
    drive(base + 8'd4, 1'b1, 1'b0, last_r);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 40;
    while (level != '0 && budget > 0) begin
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      budget--;
    end
    check({name, "_level"}, 32'(level), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic s,
                              input logic f, input logic p, input logic [31:0] q);
    vec_t t;
    t.data = d; t.valid = v; t.sof = s; t.ferr = f; t.push = p; t.quad = q;
    return t;
  endfunction

  initial begin
    // Framing vectors with out_ready=1: {data, valid, sof, frame_err next, push, quad}
    vecs.push_back(mk(8'h01, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(8'h02, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h03, 1, 1, 1, 0, 32'h0));
    vecs.push_back(mk(8'h04, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h05, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h06, 1, 0, 0, 1, 32'h06050403));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h11, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(8'h22, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'hEE, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h33, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h44, 1, 0, 0, 1, 32'h44332211));
    vecs.push_back(mk(8'h55, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(8'h66, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(8'h77, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h88, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h99, 1, 0, 0, 1, 32'h99887766));
    vecs.push_back(mk(8'hAB, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(8'hCD, 1, 1, 1, 0, 32'h0));
    vecs.push_back(mk(8'h01, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h02, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(8'h03, 1, 0, 0, 1, 32'h030201CD));

    reset = 1'b0; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_quad", out_quad, 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic group and one-cycle latency
    drive(8'h10, 1, 1, 1);
    drive(8'h20, 1, 0, 1);
    drive(8'h30, 1, 0, 1);
    check("basic_not_yet_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(32'h40302010);
    drive(8'h40, 1, 0, 1);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_quad", out_quad, 32'h40302010);
    check("basic_level1", 32'(level), 32'd1);
    drive(8'h00, 0, 0, 1);
    check("basic_level0", 32'(level), 32'd0);
    check("basic_out_valid0", 32'(out_valid), 32'd0);

    // Table-driven framing vectors
    foreach (vecs[i]) begin
      if (vecs[i].push) exp_q.push_back(vecs[i].quad);
      drive(vecs[i].data, vecs[i].valid, vecs[i].sof, 1'b1);
      check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].ferr));
    end
    drain("table_drain");

    // Fill to full, then drop the fifth group
    for (int g = 1; g <= 4; g++) begin
      exp_q.push_back(quad_of(8'(g * 16)));
      send_group(8'(g * 16), 1'b0, 1'b0);
    end
    check("full_level", 32'(level), 32'd4);
    check("full_no_overflow", 32'(overflow), 32'd0);
    send_group(8'h50, 1'b0, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    drive(8'h00, 0, 0, 0);
    check("ovf_pulse_ends", 32'(overflow), 32'd0);

    // drop_cnt saturates at 255
    for (int k = 0; k < 260; k++) send_group(8'h60, 1'b0, 1'b0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_level", 32'(level), 32'd4);
    drain("ovf_drain");

    // Full FIFO with a pop on the edge that completes another group
    for (int g = 10; g <= 13; g++) begin
      exp_q.push_back(quad_of(8'(g * 16)));
      send_group(8'(g * 16), 1'b0, 1'b0);
    end
    check("full2_level", 32'(level), 32'd4);
    exp_q.push_back(quad_of(8'hE0));
    send_group(8'hE0, 1'b0, 1'b1);
    check("pushpop_no_overflow", 32'(overflow), 32'd0);
    check("pushpop_level", 32'(level), 32'd4);
    check("pushpop_drop_cnt", 32'(drop_cnt), 32'd255);
    drain("pushpop_drain");

    // Reset mid-group with a non-empty FIFO loses everything
    send_group(8'h70, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd1);
    drive(8'hAA, 1, 1, 0);
    drive(8'hBB, 1, 0, 0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_quad", out_quad, 32'h0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("release_no_ferr", 32'(frame_err), 32'd0);
    drive(8'hCC, 1, 0, 1);
    check("postrst_ferr1", 32'(frame_err), 32'd1);
    drive(8'hDD, 1, 0, 1);
    check("postrst_ferr2", 32'(frame_err), 32'd1);
    drive(8'h00, 0, 0, 1);
    check("postrst_ferr_end", 32'(frame_err), 32'd0);
    check("postrst_level", 32'(level), 32'd0);
    check("postrst_out_valid", 32'(out_valid), 32'd0);

    repeat (3) drive(8'h00, 0, 0, 1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
